fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'd0: word address loaded into PC on reset.
REQ-002 Ports, clock and reset first:
- clk  in  1  rising-edge clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the fetch; equals PC.
- imem_ack  in  1  imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  decoded fields valid and held for the datapath.
- PC  out  32  word address of the held instruction.
- Rs/Rt/Rd  out  5 each  instr[25:21] / [20:16] / [15:11].
- imm16  out  16  instr[15:0].
- opcode, funct  out  6 each  instr[31:26], instr[5:0].
- target26  out  26  instr[25:0].
- exec_done  in  1  downstream has consumed the instruction; redirect inputs valid this cycle.
- branch, zero, jump, jr  in  1 each  control-flow qualifiers from decode/ALU.
- jr_addr  in  32  register value (Da), a byte address.
- retired  out  32  count of completed instructions.

Function
REQ-003 FSM has two states, FETCH and HOLD; reset state is FETCH.
REQ-004 imem_req SHALL be 1 iff state==FETCH and reset==0; imem_addr SHALL always equal PC.
REQ-005 FETCH with imem_ack=1: latch imem_rdata into the instruction register, set instr_valid=1, go to HOLD; zero-latency ack (same cycle as the first req) is legal.
REQ-006 FETCH with imem_ack=0: state, PC and the instruction register are held; imem_req stays 1.
REQ-007 HOLD: instr_valid=1; all field outputs are stable; imem_ack is ignored.
REQ-008 HOLD with exec_done=1: PC<=next_pc, retired<=retired+1 (mod 2^32), instr_valid<=0, go to FETCH; next fetch request is issued the following cycle.
REQ-009 HOLD with exec_done=0: no state change.
REQ-010 exec_done in FETCH is ignored.
REQ-011 next_pc selection, priority jr > jump > (branch & zero) > sequential:
- jr: jr_addr[31:2] zero-extended.
- jump: {pc1[31:26], target26}.
- taken branch: pc1 + sign_extend(imm16).
- otherwise: pc1.
- pc1 = PC+1.
REQ-012 All next_pc arithmetic is 32-bit modulo 2^32; PC=32'hFFFFFFFF sequential wraps to 0.
REQ-013 branch=1 with zero=0 is sequential; jr_addr[1:0] are discarded without error.
REQ-014 Field outputs are combinational slices of the instruction register; the register is 0 until the first ack.

Reset
REQ-015 reset=1 at a clock edge sets:
- state=FETCH, PC=RESET_PC;
- instruction register=0, instr_valid=0, retired=0;
- overrides any simultaneous imem_ack or exec_done.
REQ-016 Reset mid-fetch abandons the pending request; a late ack arriving while reset=1 is discarded.
REQ-017 First imem_req=1 occurs in the first cycle with reset=0.

Verification
REQ-018 Bench SHALL cover these directed scenarios:
- Reset then sequential: RESET_PC=0; ack each fetch after 2 cycles with 32'h00221820; pulse exec_done once per instruction -> imem_addr 0,1,2; retired=3; Rs=1, Rt=2, Rd=3.
- Taken branch: PC=10, imm16=16'hFFFC, branch=1, zero=1, exec_done -> next imem_addr=7. With zero=0 -> 11.
- Jump vs jr priority: PC=32'h0400_0005, target26=26'h10, jump=1, jr=1, jr_addr=32'h100 -> next imem_addr=32'h40. With jr=0 -> 32'h0400_0010.
- Stall hold: keep imem_ack=0 for 5 cycles in FETCH -> imem_req=1 and imem_addr constant throughout. Hold exec_done=0 in HOLD with ack pulses -> instr and PC unchanged.
- Reset mid-operation: assert reset in HOLD with exec_done=1 -> PC=RESET_PC, retired=0, instr_valid=0 next cycle; imem_req=1 the cycle after reset drops.
- Wrap: PC=32'hFFFFFFFF, sequential exec_done -> imem_addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: two-state instruction fetch sequencer.
//
// Fetches one instruction word at a time from instruction memory, holds it
// (and its decoded fields) for the datapath until the datapath reports it
// consumed, then computes the next PC from the control-flow qualifiers.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request and word address (always == PC)
//   imem_ack/imem_rdata   memory response, data valid when ack=1
//   instr_valid           held instruction and fields are valid
//   PC                    word address of the held instruction
//   Rs/Rt/Rd/imm16/opcode/funct/target26  slices of the instruction register
//   exec_done             datapath consumed the instruction; qualifiers valid
//   branch/zero/jump/jr   control-flow qualifiers, jr_addr = byte address
//   retired               completed-instruction count, wraps mod 2^32
//   state_dbg             current FSM state (0 = FETCH, 1 = HOLD)
//
// Handshake: a fetch transfers on any cycle with imem_req=1 and imem_ack=1;
// an instruction retires on any cycle with instr_valid=1 and exec_done=1.
// imem_ack is ignored outside FETCH, exec_done is ignored outside HOLD.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] imm16,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [25:0] target26,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    output logic [31:0] retired,
    output logic        state_dbg
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] pc1;
    logic [31:0] next_pc;
    logic [31:0] imm_sext;
    // Byte-offset bits of the register target are dropped on purpose.
    logic        unused_jr_low;

    assign unused_jr_low = ^jr_addr[1:0];

    assign pc1      = pc_q + 32'd1;
    assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    // Redirect priority: jr > jump > taken branch > sequential.
    always_comb begin
        next_pc = pc1;
        if (jr) begin
            next_pc = {2'b00, jr_addr[31:2]};
        end else if (jump) begin
            next_pc = {pc1[31:26], ir_q[25:0]};
        end else if (branch && zero) begin
            next_pc = pc1 + imm_sext;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (exec_done) begin
                    pc_d      = next_pc;
                    retired_d = retired_q + 32'd1;
                    state_d   = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Request is gated by reset so nothing is issued while reset is held.
    assign imem_req    = (state_q == FETCH) && !reset;
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign PC          = pc_q;
    assign retired     = retired_q;
    assign state_dbg   = state_q;

    assign opcode   = ir_q[31:26];
    assign Rs       = ir_q[25:21];
    assign Rt       = ir_q[20:16];
    assign Rd       = ir_q[15:11];
    assign imm16    = ir_q[15:0];
    assign funct    = ir_q[5:0];
    assign target26 = ir_q[25:0];

endmodule
